divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider_if.sv | 20 ++
 rtl/divider.sv | 76 +++++++
 tb/tb_divider.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/divider_if.sv
// divider_if: operand/result handshake bundle for the restoring divider.
interface divider_if #(parameter int WIDTH = 2);
    logic                 in_valid;
    logic                 in_ready;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 div_by_zero;
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider.sv
// divider: multicycle radix-2 restoring unsigned divider, 2*WIDTH-bit dividend by WIDTH-bit divisor.
module divider #(
    parameter int WIDTH = 2
) (
    input logic       clk,
    input logic       rst_n,
    divider_if.slave  d
);
    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(DW);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t            state, state_nx;
    logic [DW-1:0]     dvd;
    logic [WIDTH-1:0]  dvs;
    logic [WIDTH:0]    rem;
    logic [CW-1:0]     cnt;
    logic [WIDTH+1:0]  shifted;
    logic [WIDTH:0]    rem_nx;
    logic              ge;
    logic              zero;
    logic              last;
    // dvd doubles as the quotient shift register: dividend bits leave the top as quotient bits enter the bottom
    always_comb begin
        shifted = {rem, dvd[DW-1]};
        ge      = shifted >= (WIDTH+2)'(dvs);
        rem_nx  = ge ? (WIDTH+1)'(shifted - (WIDTH+2)'(dvs)) : shifted[WIDTH:0];
        zero    = dvs == '0;
        last    = cnt == CW'(DW - 1);
    end
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = d.in_valid ? CALC : IDLE;
            CALC:    state_nx = (zero || last) ? DONE : CALC;
            DONE:    state_nx = d.out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    assign d.in_ready  = state == IDLE;
    assign d.out_valid = state == DONE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd           <= '0;
            dvs           <= '0;
            rem           <= '0;
            cnt           <= '0;
            d.quotient    <= '0;
            d.remainder   <= '0;
            d.div_by_zero <= 1'b0;
        end else if (state == IDLE && d.in_valid) begin
            dvd <= d.dividend;
            dvs <= d.divisor;
            rem <= '0;
            cnt <= '0;
        end else if (state == CALC) begin
            if (zero) begin
                d.quotient    <= '1;
                d.remainder   <= dvd[WIDTH-1:0];
                d.div_by_zero <= 1'b1;
            end else begin
                dvd <= {dvd[DW-2:0], ge};
                rem <= rem_nx;
                if (!last) cnt <= cnt + CW'(1);
                if (last) begin
                    d.quotient    <= {dvd[DW-2:0], ge};
                    d.remainder   <= rem_nx[WIDTH-1:0];
                    d.div_by_zero <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_divider.sv
// tb_divider: directed and exhaustive checks of the restoring divider at WIDTH=2.
module tb_divider;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    always #5 clk = ~clk;
    divider_if #(.WIDTH(2)) bus();
    divider #(.WIDTH(2)) dut (.clk(clk), .rst_n(rst_n), .d(bus.slave));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    // Presents operands in the current low phase; afterwards the inputs are scrambled to prove they are ignored.
    task automatic start(input logic [3:0] a, input logic [1:0] b);
        chk("in_ready_idle", 32'(bus.in_ready), 1);
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.dividend = ~a;
        bus.divisor  = ~b;
    endtask
    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.out_valid) chk("done_timeout", 0, 1);
    endtask
    task automatic do_op(input string tag, input logic [3:0] a, input logic [1:0] b,
                         input int q, input int r, input int z, input int exp_lat);
        int lat;
        @(negedge clk);
        bus.out_ready = 1'b1;
        start(a, b);
        wait_done(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_q"}, 32'(bus.quotient), 32'(q));
        chk({tag, "_r"}, 32'(bus.remainder), 32'(r));
        chk({tag, "_z"}, 32'(bus.div_by_zero), 32'(z));
        @(posedge clk);
        #1;
        chk({tag, "_idle"}, 32'(bus.out_valid), 0);
    endtask
    initial begin
        int lat;
        int seen;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        #2;
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_q", 32'(bus.quotient), 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("d13_3", 4'd13, 2'd3, 4, 1, 0, 4);
        do_op("d15_1", 4'd15, 2'd1, 15, 0, 0, 4);
        do_op("d2_3", 4'd2, 2'd3, 0, 2, 0, 4);
        do_op("d9_0", 4'd9, 2'd0, 15, 1, 1, 1);
        do_op("d7_2", 4'd7, 2'd2, 3, 1, 0, 4);
        // Backpressure: result must hold for 5 cycles and a stray in_valid must be ignored.
        @(negedge clk);
        bus.out_ready = 1'b0;
        start(4'd11, 2'd2);
        wait_done(lat);
        chk("hold_lat", 32'(lat), 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_q", 32'(bus.quotient), 5);
            chk("hold_r", 32'(bus.remainder), 1);
            chk("hold_valid", 32'(bus.out_valid), 1);
            chk("hold_in_ready", 32'(bus.in_ready), 0);
            bus.in_valid = (i == 2);
            bus.dividend = 4'd1;
            bus.divisor  = 2'd1;
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", 32'(bus.in_ready), 1);
        chk("release_valid", 32'(bus.out_valid), 0);
        chk("retain_q", 32'(bus.quotient), 5);
        chk("retain_r", 32'(bus.remainder), 1);
        // Reset during the second CALC step clears outputs at once and suppresses the result.
        @(negedge clk);
        start(4'd13, 2'd3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_q", 32'(bus.quotient), 0);
        chk("arst_r", 32'(bus.remainder), 0);
        chk("arst_valid", 32'(bus.out_valid), 0);
        chk("arst_in_ready", 32'(bus.in_ready), 1);
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            seen |= int'(bus.out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start(4'd6, 2'd2);
        wait_done(lat);
        seen |= (lat < 4) ? 1 : 0;
        chk("arst_no_pulse", 32'(seen), 0);
        chk("post_rst_lat", 32'(lat), 4);
        chk("post_rst_q", 32'(bus.quotient), 3);
        chk("post_rst_r", 32'(bus.remainder), 0);
        @(posedge clk);
        #1;
        // Every operand pair under random output backpressure.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 4; b++) begin
                int n;
                int eq;
                int er;
                bit done;
                bit got;
                eq = (b == 0) ? 15 : a / b;
                er = (b == 0) ? (a % 4) : a % b;
                @(negedge clk);
                bus.out_ready = 1'b0;
                start(4'(a), 2'(b));
                n = 0;
                done = 1'b0;
                got = 1'b0;
                while (!done && n < 40) begin
                    @(negedge clk);
                    n++;
                    if (bus.out_valid && !got) begin
                        chk($sformatf("sb_q_%0d_%0d", a, b), 32'(bus.quotient), 32'(eq));
                        chk($sformatf("sb_r_%0d_%0d", a, b), 32'(bus.remainder), 32'(er));
                        chk($sformatf("sb_z_%0d_%0d", a, b), 32'(bus.div_by_zero), (b == 0) ? 1 : 0);
                        got = 1'b1;
                    end
                    bus.out_ready = 1'($urandom_range(0, 1));
                    done = bus.out_valid && bus.out_ready;
                end
                if (!done) chk($sformatf("sb_timeout_%0d_%0d", a, b), 0, 1);
                @(posedge clk);
                #1;
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
